// File: rtl/fir_out_collector_pkg.sv
// Shared types and defaults for the FIR chain output collector.
package fir_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned FRAME_LEN = 8000;

  typedef logic signed [DATA_W-1:0] sample_t;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN,
    DONE
  } collector_state_t;

endpackage

// File: rtl/fir_out_collector_if.sv
// Output sample stream: valid/ready with end-of-frame marker.
interface fir_out_collector_if #(
  parameter int unsigned DATA_W = 16
);

  logic signed [DATA_W-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface

// File: rtl/fir_out_collector_sync_fifo.sv
// Show-ahead synchronous FIFO with a registered head word.
module sync_fifo #(
  parameter int unsigned WIDTH = 17,
  parameter int unsigned DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_p,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] dout
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             pop_en, push_en;

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == (AW+1)'(DEPTH));
    pop_en   = pop && !empty;
    push_en  = push && (!full || pop_en);
    wr_ptr_d = wr_ptr_q + AW'(push_en);
    rd_ptr_d = rd_ptr_q + AW'(pop_en);
    count_d  = count_q + (AW+1)'(push_en) - (AW+1)'(pop_en);
    // Head register preloads the next word; bypass din when it lands in the head slot.
    dout_d   = dout_q;
    if (count_d != '0) begin
      dout_d = (push_en && (wr_ptr_q == rd_ptr_d)) ? din : mem_q[rd_ptr_d];
    end
    dout     = dout_q;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

endmodule

// File: rtl/fir_out_collector.sv
// Collects the FIR chain output: drops fill samples, rounds/shifts, buffers a frame
// and streams it out with an end-of-frame marker.
module fir_out_collector #(
  parameter int unsigned DATA_W     = fir_pkg::DATA_W,
  parameter int unsigned FILL_LAT   = 3,
  parameter int unsigned FRAME_LEN  = fir_pkg::FRAME_LEN,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                     clk,
  input  logic                     rst_p,
  input  logic                     ena,
  input  logic                     start,
  input  logic signed [DATA_W-1:0] y_in,
  fir_out_collector_if.master      m_if,
  output logic                     busy,
  output logic                     overflow,
  output logic [12:0]              sample_cnt
);

  import fir_pkg::*;

  localparam int unsigned       FILL_W    = (FILL_LAT > 1) ? $clog2(FILL_LAT + 1) : 1;
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(FILL_LAT - 1);
  localparam logic [12:0]       LAST_IDX  = 13'(FRAME_LEN - 1);

  collector_state_t         state_q, state_d;
  logic [FILL_W-1:0]        fill_cnt_q, fill_cnt_d;
  logic [12:0]              sample_cnt_q, sample_cnt_d;
  logic                     overflow_q, overflow_d;
  logic                     push, last_word, pop_ok;
  logic                     fifo_full, fifo_empty;
  logic signed [DATA_W-1:0] rounded;
  logic [DATA_W:0]          fifo_dout;

  if (SHIFT == 0) begin : g_pass
    always_comb rounded = y_in;
  end else begin : g_round
    localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(2 ** (SHIFT - 1));
    logic signed [DATA_W:0] wide;
    // One guard bit makes the half-LSB add overflow-free; the shifted result always fits DATA_W.
    always_comb begin
      wide    = $signed({y_in[DATA_W-1], y_in}) + HALF;
      rounded = DATA_W'(wide >>> SHIFT);
    end
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (FILL_LAT == 0) ? RUN : FILL;
      FILL:    if (ena && (fill_cnt_q == FILL_LAST)) state_d = RUN;
      RUN:     if (ena && (sample_cnt_q == LAST_IDX)) state_d = DONE;
      DONE:    if (fifo_empty) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state_q != IDLE);
    push         = (state_q == RUN) && ena;
    last_word    = (sample_cnt_q == LAST_IDX);
    pop_ok       = m_if.m_ready && !fifo_empty;
    fill_cnt_d   = fill_cnt_q;
    sample_cnt_d = sample_cnt_q;
    overflow_d   = overflow_q;
    if ((state_q == IDLE) && start) begin
      fill_cnt_d   = '0;
      sample_cnt_d = '0;
      overflow_d   = 1'b0;
    end
    if ((state_q == FILL) && ena) fill_cnt_d = fill_cnt_q + FILL_W'(1);
    // Dropped samples still count so the frame boundary stays aligned with the source.
    if (push) begin
      sample_cnt_d = sample_cnt_q + 13'd1;
      if (fifo_full && !pop_ok) overflow_d = 1'b1;
    end
    overflow   = overflow_q;
    sample_cnt = sample_cnt_q;
  end

  always_ff @(posedge clk or posedge rst_p) begin
    if (rst_p) begin
      fill_cnt_q   <= '0;
      sample_cnt_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      fill_cnt_q   <= fill_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  sync_fifo #(
    .WIDTH(DATA_W + 1),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_p(rst_p),
    .push (push),
    .pop  (m_if.m_ready),
    .din  ({last_word, rounded}),
    .full (fifo_full),
    .empty(fifo_empty),
    .dout (fifo_dout)
  );

  always_comb begin
    m_if.m_valid = !fifo_empty;
    m_if.m_data  = fifo_dout[DATA_W-1:0];
    m_if.m_last  = fifo_dout[DATA_W] && !fifo_empty;
  end

endmodule

// File: tb/tb_fir_out_collector.sv
// Directed bench for fir_out_collector using three parameterisations on one clock.
module tb_fir_out_collector;

  logic               clk = 1'b0;
  logic               rst_p;
  logic               ena;
  logic               start;
  logic signed [15:0] y_in;

  logic        busy_a, ovf_a, busy_b, ovf_b, busy_c, ovf_c;
  logic [12:0] cnt_a, cnt_b, cnt_c;

  int n_cmp = 0;
  int n_bad = 0;

  fir_out_collector_if #(.DATA_W(16)) a_if ();
  fir_out_collector_if #(.DATA_W(16)) b_if ();
  fir_out_collector_if #(.DATA_W(16)) c_if ();

  fir_out_collector #(
    .DATA_W(16), .FILL_LAT(3), .FRAME_LEN(32), .FIFO_DEPTH(16), .SHIFT(0)
  ) u_a (
    .clk(clk), .rst_p(rst_p), .ena(ena), .start(start), .y_in(y_in),
    .m_if(a_if), .busy(busy_a), .overflow(ovf_a), .sample_cnt(cnt_a)
  );

  fir_out_collector #(
    .DATA_W(16), .FILL_LAT(0), .FRAME_LEN(8), .FIFO_DEPTH(16), .SHIFT(2)
  ) u_b (
    .clk(clk), .rst_p(rst_p), .ena(ena), .start(start), .y_in(y_in),
    .m_if(b_if), .busy(busy_b), .overflow(ovf_b), .sample_cnt(cnt_b)
  );

  fir_out_collector #(
    .DATA_W(16), .FILL_LAT(0), .FRAME_LEN(8), .FIFO_DEPTH(16), .SHIFT(1)
  ) u_c (
    .clk(clk), .rst_p(rst_p), .ena(ena), .start(start), .y_in(y_in),
    .m_if(c_if), .busy(busy_c), .overflow(ovf_c), .sample_cnt(cnt_c)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_p = 1'b1;
    tick();
    rst_p = 1'b0;
    tick();
  endtask

  logic signed [15:0] vec_y [8] = '{16'sd6, -16'sd6, -16'sd32768, 16'sd32767,
                                    16'sd0, 16'sd4, 16'sd8, 16'sd12};
  int                 vec_b [8] = '{2, -1, -8192, 8192, 0, 1, 2, 3};

  initial begin
    rst_p = 1'b1; ena = 1'b0; start = 1'b0; y_in = '0;
    a_if.m_ready = 1'b0; b_if.m_ready = 1'b0; c_if.m_ready = 1'b0;
    tick();
    tick();
    rst_p = 1'b0;
    tick();

    check("rst_busy",  busy_a, 0);
    check("rst_valid", a_if.m_valid, 0);
    check("rst_data",  a_if.m_data, 0);
    check("rst_last",  a_if.m_last, 0);
    check("rst_ovf",   ovf_a, 0);
    check("rst_cnt",   cnt_a, 0);

    // Fill discard: first three ena samples never reach the stream
    a_if.m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("fill_busy", busy_a, 1);
    for (int i = 1; i <= 5; i++) begin
      y_in = 16'(i);
      ena  = 1'b1;
      tick();
      if (i <= 3) check("fill_discard_valid", a_if.m_valid, 0);
      else begin
        check("fill_valid", a_if.m_valid, 1);
        check("fill_data", a_if.m_data, i);
      end
    end
    ena = 1'b0;
    tick();
    check("fill_drained", a_if.m_valid, 0);
    check("fill_hold", a_if.m_data, 5);
    check("fill_cnt", cnt_a, 2);

    // Asynchronous reset with five words buffered
    a_if.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      y_in = 16'(10 + i);
      ena  = 1'b1;
      tick();
    end
    ena = 1'b0;
    check("pre_rst_valid", a_if.m_valid, 1);
    check("pre_rst_cnt", cnt_a, 7);
    #2;
    rst_p = 1'b1;
    #1;
    check("async_valid", a_if.m_valid, 0);
    check("async_busy", busy_a, 0);
    check("async_ovf", ovf_a, 0);
    check("async_cnt", cnt_a, 0);
    tick();
    rst_p = 1'b0;
    tick();

    // Backpressure: 20 samples into a 16-deep FIFO
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 23; i++) begin
      y_in = (i < 3) ? 16'sd100 : 16'(i - 3);
      ena  = 1'b1;
      tick();
    end
    ena = 1'b0;
    check("bp_ovf", ovf_a, 1);
    check("bp_cnt", cnt_a, 20);
    check("bp_valid", a_if.m_valid, 1);
    a_if.m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("bp_pop_data", a_if.m_data, k);
      tick();
    end
    check("bp_empty", a_if.m_valid, 0);
    a_if.m_ready = 1'b0;

    // Full FIFO with push and pop in the same cycle
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 19; i++) begin
      y_in = (i < 3) ? 16'sd0 : 16'(197 + i);
      ena  = 1'b1;
      tick();
    end
    check("full_head", a_if.m_data, 200);
    check("full_ovf_pre", ovf_a, 0);
    y_in = 16'sd216;
    a_if.m_ready = 1'b1;
    tick();
    ena = 1'b0;
    a_if.m_ready = 1'b0;
    check("full_ovf", ovf_a, 0);
    check("full_cnt", cnt_a, 17);
    a_if.m_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check("full_pop_valid", a_if.m_valid, 1);
      check("full_pop_data", a_if.m_data, 201 + k);
      tick();
    end
    check("full_empty", a_if.m_valid, 0);
    a_if.m_ready = 1'b0;

    // Rounding and frame end on the FRAME_LEN=8 instances
    do_reset();
    b_if.m_ready = 1'b1;
    c_if.m_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      y_in = vec_y[i];
      ena  = 1'b1;
      tick();
      check("rnd_valid", b_if.m_valid, 1);
      check("rnd_data", b_if.m_data, vec_b[i]);
      check("frame_last", b_if.m_last, (i == 7) ? 1 : 0);
      if (i == 3) check("rnd_shift1", c_if.m_data, 16384);
    end
    ena = 1'b0;
    check("done_busy", busy_b, 1);
    tick();
    check("done_drained", b_if.m_valid, 0);
    tick();
    check("done_idle", busy_b, 0);
    for (int i = 0; i < 3; i++) begin
      y_in = 16'sd5;
      ena  = 1'b1;
      tick();
    end
    ena = 1'b0;
    check("idle_ena_valid", b_if.m_valid, 0);
    check("idle_ena_cnt", cnt_b, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
